// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the multi-channel clock divider.
package clk_div_pkg;

    typedef enum logic {
        TOGGLE = 1'b0,
        PULSE  = 1'b1
    } mode_e;

    localparam int          DEF_CNT_W = 32;
    localparam int unsigned DEF_DIV   = 5000000;

    // A single-channel build still needs a one-bit channel select.
    function automatic int chanSelWidth(input int numCh);
        return (numCh > 1) ? $clog2(numCh) : 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: shadowed divisor/mode, terminal counter and registered outputs.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int          CNT_W       = DEF_CNT_W,
    parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_restart,
    input  logic             i_wrHit,
    input  logic [CNT_W-1:0] i_wrDiv,
    input  mode_e            i_wrMode,
    output logic             o_divOut,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_activeDiv;
    logic [CNT_W-1:0] r_shadowDiv;
    mode_e            r_activeMode;
    mode_e            r_shadowMode;
    logic             r_divOut;
    logic             r_tc;

    logic [CNT_W-1:0] w_nextDiv;
    mode_e            w_nextMode;
    logic             w_terminal;

    // A write landing in the same cycle as a reload goes straight to the active registers.
    assign w_nextDiv  = i_wrHit ? i_wrDiv  : r_shadowDiv;
    assign w_nextMode = i_wrHit ? i_wrMode : r_shadowMode;
    assign w_terminal = (r_count >= r_activeDiv);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadowDiv  <= RESET_DIV;
            r_shadowMode <= TOGGLE;
        end else if (i_wrHit) begin
            r_shadowDiv  <= i_wrDiv;
            r_shadowMode <= i_wrMode;
        end
    end

    // Disable and restart both park the channel at count 0 and pick up the latest configuration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count      <= '0;
            r_activeDiv  <= RESET_DIV;
            r_activeMode <= TOGGLE;
            r_divOut     <= 1'b0;
            r_tc         <= 1'b0;
        end else if (!i_en || i_restart) begin
            r_count      <= '0;
            r_activeDiv  <= w_nextDiv;
            r_activeMode <= w_nextMode;
            r_divOut     <= 1'b0;
            r_tc         <= 1'b0;
        end else if (w_terminal) begin
            r_count      <= '0;
            r_activeDiv  <= w_nextDiv;
            r_activeMode <= w_nextMode;
            r_divOut     <= (r_activeMode == PULSE) ? 1'b1 : ~r_divOut;
            r_tc         <= 1'b1;
        end else begin
            r_count      <= r_count + CNT_W'(1);
            r_divOut     <= (r_activeMode == PULSE) ? 1'b0 : r_divOut;
            r_tc         <= 1'b0;
        end
    end

    assign o_divOut = r_divOut;
    assign o_tc     = r_tc;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider: decodes configuration writes and fans them out to the channels.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = DEF_CNT_W,
    parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              wr_en,
    input  logic [chanSelWidth(NUM_CH)-1:0]   wr_ch,
    input  logic [CNT_W-1:0]                  wr_div,
    input  logic                              wr_mode,
    input  logic [NUM_CH-1:0]                 ch_en,
    input  logic                              restart,
    output logic [NUM_CH-1:0]                 div_out,
    output logic [NUM_CH-1:0]                 tc
);

    localparam int CH_W = chanSelWidth(NUM_CH);

    mode_e w_wrMode;

    assign w_wrMode = mode_e'(wr_mode);

    // Selects that match no channel simply hit nothing.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic w_wrHit;

        assign w_wrHit = wr_en && (wr_ch == CH_W'(i));

        clk_div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_channel (
            .clk       (clk),
            .reset     (reset),
            .i_en      (ch_en[i]),
            .i_restart (restart),
            .i_wrHit   (w_wrHit),
            .i_wrDiv   (wr_div),
            .i_wrMode  (w_wrMode),
            .o_divOut  (div_out[i]),
            .o_tc      (tc[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench: directed literal scenarios plus random traffic against a countdown model.
module tb_clk_div_multi;

    localparam int NUM_CH     = 3;
    localparam int CNT_W      = 8;
    localparam int DEF_DIV_TB = 6;
    localparam int CH_W       = 2;

    logic              clk     = 1'b0;
    logic              reset   = 1'b1;
    logic              wr_en   = 1'b0;
    logic [CH_W-1:0]   wr_ch   = '0;
    logic [CNT_W-1:0]  wr_div  = '0;
    logic              wr_mode = 1'b0;
    logic [NUM_CH-1:0] ch_en   = '0;
    logic              restart = 1'b0;
    logic [NUM_CH-1:0] div_out;
    logic [NUM_CH-1:0] tc;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF_DIV_TB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .wr_mode (wr_mode),
        .ch_en   (ch_en),
        .restart (restart),
        .div_out (div_out),
        .tc      (tc)
    );

    // Model: each channel counts down the edges left before its next tick.
    int mRem[NUM_CH];
    int mSh[NUM_CH];
    bit mShPulse[NUM_CH];
    bit mActPulse[NUM_CH];
    bit mOut[NUM_CH];
    bit mTc[NUM_CH];

    function automatic bit hitOf(input int c);
        return wr_en && (int'(wr_ch) == c);
    endfunction

    function automatic int newDivOf(input int c);
        return hitOf(c) ? int'(wr_div) : mSh[c];
    endfunction

    function automatic bit newPulseOf(input int c);
        return hitOf(c) ? wr_mode : mShPulse[c];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                mRem[c]      <= DEF_DIV_TB;
                mSh[c]       <= DEF_DIV_TB;
                mShPulse[c]  <= 1'b0;
                mActPulse[c] <= 1'b0;
                mOut[c]      <= 1'b0;
                mTc[c]       <= 1'b0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (hitOf(c)) begin
                    mSh[c]      <= newDivOf(c);
                    mShPulse[c] <= newPulseOf(c);
                end
                if (!ch_en[c] || restart) begin
                    mRem[c]      <= newDivOf(c);
                    mActPulse[c] <= newPulseOf(c);
                    mOut[c]      <= 1'b0;
                    mTc[c]       <= 1'b0;
                end else if (mRem[c] == 0) begin
                    mRem[c]      <= newDivOf(c);
                    mActPulse[c] <= newPulseOf(c);
                    mOut[c]      <= mActPulse[c] ? 1'b1 : !mOut[c];
                    mTc[c]       <= 1'b1;
                end else begin
                    mRem[c] <= mRem[c] - 1;
                    mTc[c]  <= 1'b0;
                    if (mActPulse[c]) mOut[c] <= 1'b0;
                end
            end
        end
    end

    function automatic logic [NUM_CH-1:0] packOut();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = mOut[c];
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] packTc();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = mTc[c];
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model div_out", 32'(div_out), 32'(packOut()));
        checkOutput("model tc", 32'(tc), 32'(packTc()));
    end

    task automatic cycle(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus();
        wr_en   = ($urandom_range(0, 3) == 0);
        wr_ch   = CH_W'($urandom_range(0, 3));
        wr_div  = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom_range(0, 40)) : CNT_W'($urandom_range(0, 6));
        wr_mode = 1'($urandom_range(0, 1));
        restart = ($urandom_range(0, 39) == 0);
        for (int c = 0; c < NUM_CH; c++)
            if ($urandom_range(0, 15) == 0) ch_en[c] = ~ch_en[c];
    endtask

    task automatic setWrite(input int ch, input int div, input bit pulse);
        wr_en   = 1'b1;
        wr_ch   = CH_W'(ch);
        wr_div  = CNT_W'(div);
        wr_mode = pulse;
    endtask

    initial begin
        cycle(2);
        checkOutput("reset div_out", 32'(div_out), 32'd0);
        checkOutput("reset tc", 32'(tc), 32'd0);

        // ch0 div=3 toggle, aligned by restart: period 8, tick every 4.
        reset = 1'b0;
        ch_en = 3'b001;
        setWrite(0, 3, 1'b0);
        cycle();
        wr_en   = 1'b0;
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        checkOutput("restart ch0 out", 32'(div_out[0]), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            cycle();
            checkOutput("div3 tc0", 32'(tc[0]), 32'((k % 4) == 0));
            checkOutput("div3 out0", 32'(div_out[0]), 32'(k >= 4 && k < 8));
        end

        // ch1 div=2 pulse: high one cycle in three, then div=0 holds it high.
        setWrite(1, 2, 1'b1);
        cycle();
        wr_en = 1'b0;
        ch_en = 3'b011;
        for (int k = 0; k <= 8; k++) begin
            cycle();
            checkOutput("pulse div2 out1", 32'(div_out[1]), 32'(k == 2 || k == 5 || k == 8));
        end
        setWrite(1, 0, 1'b1);
        cycle();
        wr_en = 1'b0;
        cycle();
        for (int k = 0; k < 6; k++) begin
            cycle();
            checkOutput("pulse div0 out1", 32'(div_out[1]), 32'd1);
        end

        // ch0 div=9, rewritten to 4 at count 5: ticks at 10, 15, 20.
        setWrite(0, 9, 1'b0);
        cycle();
        wr_en   = 1'b0;
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 6) setWrite(0, 4, 1'b0);
            else wr_en = 1'b0;
            cycle();
            checkOutput("shadow tc0", 32'(tc[0]), 32'(k == 10 || k == 15 || k == 20));
            checkOutput("shadow out0", 32'(div_out[0]), 32'((k >= 10 && k < 15) || k >= 20));
        end
        wr_en = 1'b0;

        // ch2 div 5 -> 1 written on the terminal cycle: next tick two cycles later.
        setWrite(2, 5, 1'b0);
        cycle();
        wr_en   = 1'b0;
        ch_en   = 3'b111;
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 6) setWrite(2, 1, 1'b0);
            else wr_en = 1'b0;
            cycle();
            checkOutput("coincident tc2", 32'(tc[2]), 32'(k == 6 || k == 8 || k == 10));
        end
        wr_en = 1'b0;

        // Restart and asynchronous reset mid-period, then an ignored out-of-range write.
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        checkOutput("restart all out", 32'(div_out), 32'd0);
        checkOutput("restart all tc", 32'(tc), 32'd0);
        cycle();
        #1 reset = 1'b1;
        #1;
        checkOutput("async reset out", 32'(div_out), 32'd0);
        checkOutput("async reset tc", 32'(tc), 32'd0);
        #1 reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (k == 1) setWrite(3, 1, 1'b1);
            else wr_en = 1'b0;
            cycle();
            checkOutput("aligned tc", 32'(tc), (k == 7) ? 32'h7 : 32'h0);
            checkOutput("aligned out", 32'(div_out), (k == 7) ? 32'h7 : 32'h0);
        end
        wr_en = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            applyStimulus();
            cycle();
            if ($urandom_range(0, 299) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
        end

        wr_en   = 1'b0;
        restart = 1'b0;
        cycle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
